// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, {C,S,V,Z} status layout and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SHR  = 4'h0,
    OP_SHL  = 4'h1,
    OP_ROR  = 4'h2,
    OP_ROL  = 4'h3,
    OP_INC  = 4'h4,
    OP_DEC  = 4'h5,
    OP_ADD  = 4'h6,
    OP_SUB  = 4'h7,
    OP_NOT  = 4'h8,
    OP_AND  = 4'h9,
    OP_OR   = 4'hA,
    OP_XOR  = 4'hB,
    OP_MOV  = 4'hC,
    OP_SHRN = 4'hD,
    OP_SHLN = 4'hE,
    OP_MUL  = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic s;
    logic v;
    logic z;
  } status_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int STATUS_C = 3;
  localparam int STATUS_S = 2;
  localparam int STATUS_V = 1;
  localparam int STATUS_Z = 0;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU datapath. Shifts/rotates/logic ops keep V (and logic ops keep C);
// SHRN/SHLN here only cover n=0 (result=a, C and V passed through).
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] res,
  output status_t          st
);

  logic [WIDTH:0] sum;
  logic           c;
  logic           v;
  logic           defined;

  always_comb begin
    sum     = '0;
    res     = '0;
    c       = c_in;
    v       = v_in;
    defined = 1'b1;
    case (op)
      OP_SHR:  begin res = a >> 1; c = a[0]; end
      OP_SHL:  begin res = a << 1; c = a[WIDTH-1]; end
      OP_ROR:  begin res = {c_in, a[WIDTH-1:1]}; c = a[0]; end
      OP_ROL:  begin res = {a[WIDTH-2:0], c_in}; c = a[WIDTH-1]; end
      OP_INC: begin
        sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = ~a[WIDTH-1] & res[WIDTH-1];
      end
      // DEC adds all-ones, so C=1 means no borrow, matching SUB.
      OP_DEC: begin
        sum = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = a[WIDTH-1] & ~res[WIDTH-1];
      end
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MOV:  res = a;
      OP_SHRN, OP_SHLN: res = a;
      default: defined = 1'b0;
    endcase

    st.c = defined & c;
    st.s = defined & res[WIDTH-1];
    st.v = defined & v;
    st.z = defined & (res == '0);
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: FSM, bit-serial shifter and counter around alu_comb.
// Define SEQ_ALU_MUL_EN to make op F an unsigned shift-add multiply.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       status_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] result_hi_out,
  output logic [3:0]       status_out,
  output alu_state_e       state_dbg
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready (IDLE only);
  // a result transfers on a rising edge with out_valid && out_ready (DONE only).
  alu_op_e          op;
  alu_op_e          op_q;
  alu_state_e       state;
  logic [WIDTH-1:0] comb_res;
  status_t          comb_st;
  status_t          run_st;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nx;
  logic             c_q;
  logic             c_nx;
  logic             v_q;
  logic [CW-1:0]    cnt_q;
  logic [SHW-1:0]   n;
  logic             is_shift_run;

  assign op           = alu_op_e'(op_in);
  assign n            = b_in[SHW-1:0];
  assign is_shift_run = ((op == OP_SHRN) || (op == OP_SHLN)) && (n != '0);
  assign state_dbg    = state;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op   (op),
    .a    (a_in),
    .b    (b_in),
    .c_in (status_in[STATUS_C]),
    .v_in (status_in[STATUS_V]),
    .res  (comb_res),
    .st   (comb_st)
  );

`ifdef SEQ_ALU_MUL_EN
  // Multiply: sh_q holds the multiplier (low half of the product grows in from the top).
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] ma_q;
  logic [WIDTH:0]   mul_sum;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (sh_q[0] ? {1'b0, ma_q} : '0);
    hi_nx   = mul_sum[WIDTH:1];
  end
`else
  assign result_hi_out = '0;
`endif

  always_comb begin
    sh_nx = sh_q;
    c_nx  = c_q;
    if (op_q == OP_SHRN) begin
      sh_nx = sh_q >> 1;
      c_nx  = sh_q[0];
    end else if (op_q == OP_SHLN) begin
      sh_nx = sh_q << 1;
      c_nx  = sh_q[WIDTH-1];
    end
`ifdef SEQ_ALU_MUL_EN
    else if (op_q == OP_MUL) begin
      sh_nx = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
`endif

    run_st.c = c_nx;
    run_st.s = sh_nx[WIDTH-1];
    run_st.v = v_q;
    run_st.z = (sh_nx == '0);
`ifdef SEQ_ALU_MUL_EN
    if (op_q == OP_MUL) begin
      run_st.c = |hi_nx;
      run_st.v = |hi_nx;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result_out <= '0;
      status_out <= '0;
      op_q       <= OP_SHR;
      sh_q       <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      cnt_q      <= '0;
`ifdef SEQ_ALU_MUL_EN
      hi_q          <= '0;
      ma_q          <= '0;
      result_hi_out <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            sh_q     <= a_in;
            c_q      <= status_in[STATUS_C];
            v_q      <= status_in[STATUS_V];
            cnt_q    <= CW'(n);
            in_ready <= 1'b0;
            if (is_shift_run) begin
              state <= RUN;
            end
`ifdef SEQ_ALU_MUL_EN
            else if (op == OP_MUL) begin
              state <= RUN;
              sh_q  <= b_in;
              ma_q  <= a_in;
              hi_q  <= '0;
              cnt_q <= CW'(WIDTH);
            end
`endif
            else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              result_out <= comb_res;
              status_out <= comb_st;
`ifdef SEQ_ALU_MUL_EN
              result_hi_out <= '0;
`endif
            end
          end
        end
        // The final step's outputs are taken from the next-step values so DONE lands on that edge.
        RUN: begin
          sh_q  <= sh_nx;
          c_q   <= c_nx;
          cnt_q <= cnt_q - 1'b1;
`ifdef SEQ_ALU_MUL_EN
          hi_q  <= hi_nx;
`endif
          if (cnt_q == CW'(1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            result_out <= sh_nx;
            status_out <= run_st;
`ifdef SEQ_ALU_MUL_EN
            result_hi_out <= (op_q == OP_MUL) ? hi_nx : '0;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
